// File: rtl/layer_priority_compositor.sv
// Per-pixel layer arbiter: picks the highest-priority opaque colour code from NUM_LAYERS layers,
// with frame-synchronous per-layer enable/flash configuration. Two-cycle pipeline, no stalls.
module layer_priority_compositor #(
    parameter int unsigned NUM_LAYERS   = 4,
    parameter int unsigned CODE_W       = 6,
    parameter int unsigned FLASH_FRAMES = 16,
    parameter int unsigned BG_CODE      = 13,
    localparam int unsigned LAYER_W     = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
    input  logic                         Clk,
    input  logic                         Reset_n,
    input  logic                         frame_start,
    input  logic                         cfg_we,
    input  logic [NUM_LAYERS-1:0]        cfg_enable,
    input  logic [NUM_LAYERS-1:0]        cfg_flash,
    input  logic                         pix_valid,
    input  logic [NUM_LAYERS*CODE_W-1:0] layer_codes,
    output logic                         out_valid,
    output logic [CODE_W-1:0]            out_code,
    output logic [LAYER_W-1:0]           out_layer,
    output logic                         out_hit,
    output logic                         flash_phase
);

    localparam int unsigned CNT_W = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;

    logic [NUM_LAYERS-1:0]        pend_en_q, pend_en_d;
    logic [NUM_LAYERS-1:0]        pend_fl_q, pend_fl_d;
    logic [NUM_LAYERS-1:0]        act_en_q, act_en_d;
    logic [NUM_LAYERS-1:0]        act_fl_q, act_fl_d;
    logic [CNT_W-1:0]             frame_cnt_q, frame_cnt_d;
    logic                         flash_phase_q, flash_phase_d;

    logic                         s1_valid_q;
    logic [NUM_LAYERS*CODE_W-1:0] s1_codes_q;
    logic [NUM_LAYERS-1:0]        s1_opaque_q, s1_opaque_d;

    logic                         out_valid_q, out_valid_d;
    logic [CODE_W-1:0]            out_code_q, out_code_d;
    logic [LAYER_W-1:0]           out_layer_q, out_layer_d;
    logic                         out_hit_q, out_hit_d;

    logic [NUM_LAYERS-1:0]        mask;

    // Configuration and flash timing; a write coincident with frame_start goes straight to active.
    always_comb begin
        pend_en_d     = pend_en_q;
        pend_fl_d     = pend_fl_q;
        act_en_d      = act_en_q;
        act_fl_d      = act_fl_q;
        frame_cnt_d   = frame_cnt_q;
        flash_phase_d = flash_phase_q;
        if (cfg_we) begin
            pend_en_d = cfg_enable;
            pend_fl_d = cfg_flash;
        end
        if (frame_start) begin
            act_en_d = cfg_we ? cfg_enable : pend_en_q;
            act_fl_d = cfg_we ? cfg_flash  : pend_fl_q;
            if (frame_cnt_q == CNT_W'(FLASH_FRAMES - 1)) begin
                frame_cnt_d   = '0;
                flash_phase_d = ~flash_phase_q;
            end else begin
                frame_cnt_d = frame_cnt_q + 1'b1;
            end
        end
    end

    // Stage 1 sees only the pre-edge config, so a pixel coincident with frame_start uses the old one.
    always_comb begin
        mask = act_en_q & ~(act_fl_q & {NUM_LAYERS{flash_phase_q}});
        for (int i = 0; i < NUM_LAYERS; i++) begin
            s1_opaque_d[i] = (layer_codes[i*CODE_W +: CODE_W] != '0) & mask[i];
        end
    end

    // Stage 2: fixed priority, lowest index wins; iterate downward so the last hit is the lowest.
    always_comb begin
        out_valid_d = s1_valid_q;
        out_code_d  = '0;
        out_layer_d = '0;
        out_hit_d   = 1'b0;
        if (s1_valid_q) begin
            out_code_d = CODE_W'(BG_CODE);
            for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
                if (s1_opaque_q[i]) begin
                    out_code_d  = s1_codes_q[i*CODE_W +: CODE_W];
                    out_layer_d = LAYER_W'(i);
                    out_hit_d   = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            pend_en_q     <= '1;
            pend_fl_q     <= '0;
            act_en_q      <= '1;
            act_fl_q      <= '0;
            frame_cnt_q   <= '0;
            flash_phase_q <= 1'b0;
            s1_valid_q    <= 1'b0;
            s1_codes_q    <= '0;
            s1_opaque_q   <= '0;
            out_valid_q   <= 1'b0;
            out_code_q    <= '0;
            out_layer_q   <= '0;
            out_hit_q     <= 1'b0;
        end else begin
            pend_en_q     <= pend_en_d;
            pend_fl_q     <= pend_fl_d;
            act_en_q      <= act_en_d;
            act_fl_q      <= act_fl_d;
            frame_cnt_q   <= frame_cnt_d;
            flash_phase_q <= flash_phase_d;
            s1_valid_q    <= pix_valid;
            s1_codes_q    <= layer_codes;
            s1_opaque_q   <= s1_opaque_d;
            out_valid_q   <= out_valid_d;
            out_code_q    <= out_code_d;
            out_layer_q   <= out_layer_d;
            out_hit_q     <= out_hit_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_code    = out_code_q;
    assign out_layer   = out_layer_q;
    assign out_hit     = out_hit_q;
    assign flash_phase = flash_phase_q;

endmodule

// File: tb/tb_layer_priority_compositor.sv
// Self-checking bench for layer_priority_compositor: vector table, directed sequences and
// random traffic against a frame-counting reference model.
module tb_layer_priority_compositor;

    localparam int NL = 4;
    localparam int CW = 6;
    localparam int FF = 16;
    localparam int BG = 13;

    logic             Clk = 1'b0;
    logic             Reset_n = 1'b0;
    logic             frame_start = 1'b0;
    logic             cfg_we = 1'b0;
    logic [NL-1:0]    cfg_enable = '0;
    logic [NL-1:0]    cfg_flash = '0;
    logic             pix_valid = 1'b0;
    logic [NL*CW-1:0] layer_codes = '0;
    logic             out_valid;
    logic [CW-1:0]    out_code;
    logic [1:0]       out_layer;
    logic             out_hit;
    logic             flash_phase;

    layer_priority_compositor #(
        .NUM_LAYERS  (NL),
        .CODE_W      (CW),
        .FLASH_FRAMES(FF),
        .BG_CODE     (BG)
    ) dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .frame_start(frame_start),
        .cfg_we     (cfg_we),
        .cfg_enable (cfg_enable),
        .cfg_flash  (cfg_flash),
        .pix_valid  (pix_valid),
        .layer_codes(layer_codes),
        .out_valid  (out_valid),
        .out_code   (out_code),
        .out_layer  (out_layer),
        .out_hit    (out_hit),
        .flash_phase(flash_phase)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        int v;
        int code;
        int layer;
        int hit;
    } exp_t;

    typedef struct {
        logic [3:0]  en;
        logic [23:0] codes;
        int          code;
        int          layer;
        int          hit;
    } vec_t;

    int checks = 0;
    int failures = 0;

    // Reference model state
    logic [3:0] m_pend_en, m_pend_fl, m_act_en, m_act_fl;
    int         m_frames;
    exp_t       d1;

    function automatic logic [23:0] pk(input int c0, input int c1, input int c2, input int c3);
        logic [5:0] a, b, c, d;
        a = c0[5:0];
        b = c1[5:0];
        c = c2[5:0];
        d = c3[5:0];
        return {d, c, b, a};
    endfunction

    function automatic int m_phase();
        return (m_frames / FF) % 2;
    endfunction

    function automatic exp_t m_pixel(input logic pv, input logic [23:0] codes);
        exp_t r;
        r = '{v: 0, code: 0, layer: 0, hit: 0};
        if (pv) begin
            r = '{v: 1, code: BG, layer: 0, hit: 0};
            for (int i = 0; i < NL; i++) begin
                int c;
                bit visible;
                c = int'(codes[i*CW +: CW]);
                visible = m_act_en[i] && !(m_act_fl[i] && m_phase() == 1);
                if (c != 0 && visible) begin
                    r = '{v: 1, code: c, layer: i, hit: 1};
                    break;
                end
            end
        end
        return r;
    endfunction

    task automatic m_reset();
        m_pend_en = 4'hF;
        m_act_en  = 4'hF;
        m_pend_fl = 4'h0;
        m_act_fl  = 4'h0;
        m_frames  = 0;
        d1 = '{v: 0, code: 0, layer: 0, hit: 0};
    endtask

    task automatic cmp(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Called with Clk low; drives one cycle and checks the output the model predicts for it.
    task automatic step(input logic fs, input logic we, input logic [3:0] en, input logic [3:0] fl,
                        input logic pv, input logic [23:0] codes);
        exp_t cur;
        frame_start = fs;
        cfg_we      = we;
        cfg_enable  = en;
        cfg_flash   = fl;
        pix_valid   = pv;
        layer_codes = codes;
        cur = m_pixel(pv, codes);
        @(posedge Clk);
        if (fs) begin
            m_act_en = we ? en : m_pend_en;
            m_act_fl = we ? fl : m_pend_fl;
            m_frames++;
        end
        if (we) begin
            m_pend_en = en;
            m_pend_fl = fl;
        end
        #1;
        cmp("model_valid", int'(out_valid), d1.v);
        cmp("model_code", int'(out_code), d1.code);
        cmp("model_layer", int'(out_layer), d1.layer);
        cmp("model_hit", int'(out_hit), d1.hit);
        cmp("model_phase", int'(flash_phase), m_phase());
        d1 = cur;
        @(negedge Clk);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 24'h0);
    endtask

    task automatic frame();
        step(1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 24'h0);
    endtask

    // One pixel then one bubble; the pixel's result is then on the outputs.
    task automatic pix_check(input string nm, input logic [23:0] codes, input int ec, input int el,
                             input int eh);
        step(1'b0, 1'b0, 4'h0, 4'h0, 1'b1, codes);
        idle();
        cmp({nm, "_valid"}, int'(out_valid), 1);
        cmp({nm, "_code"}, int'(out_code), ec);
        cmp({nm, "_layer"}, int'(out_layer), el);
        cmp({nm, "_hit"}, int'(out_hit), eh);
    endtask

    task automatic do_reset();
        Reset_n = 1'b0;
        frame_start = 1'b0;
        cfg_we = 1'b0;
        pix_valid = 1'b0;
        layer_codes = '0;
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;
        m_reset();
    endtask

    vec_t vecs[10];
    logic [23:0] t1;

    initial begin
        m_reset();
        @(negedge Clk);
        do_reset();
        t1 = pk(0, 3, 2, 4);

        // Reset state
        cmp("rst_valid", int'(out_valid), 0);
        cmp("rst_code", int'(out_code), 0);
        cmp("rst_phase", int'(flash_phase), 0);

        // Test 1
        pix_check("t1", t1, 3, 1, 1);

        // Vector table
        vecs[0] = '{4'hF, pk(0, 3, 2, 4), 3, 1, 1};
        vecs[1] = '{4'hF, pk(0, 0, 0, 0), 13, 0, 0};
        vecs[2] = '{4'h0, pk(5, 3, 2, 4), 13, 0, 0};
        vecs[3] = '{4'hF, pk(5, 3, 2, 4), 5, 0, 1};
        vecs[4] = '{4'hE, pk(5, 3, 2, 4), 3, 1, 1};
        vecs[5] = '{4'h8, pk(5, 3, 2, 4), 4, 3, 1};
        vecs[6] = '{4'hF, pk(0, 0, 0, 63), 63, 3, 1};
        vecs[7] = '{4'hF, pk(0, 14, 0, 0), 14, 1, 1};
        vecs[8] = '{4'h4, pk(0, 0, 0, 7), 13, 0, 0};
        vecs[9] = '{4'h3, pk(0, 0, 9, 0), 13, 0, 0};
        for (int k = 0; k < 10; k++) begin
            step(1'b1, 1'b1, vecs[k].en, 4'h0, 1'b0, 24'h0);
            pix_check($sformatf("vec%0d", k), vecs[k].codes, vecs[k].code, vecs[k].layer,
                      vecs[k].hit);
        end

        // Test 3: mid-frame write is deferred, frame_start applies it, coincident write-through
        do_reset();
        step(1'b0, 1'b1, 4'b1101, 4'h0, 1'b0, 24'h0);
        pix_check("t3_mid", t1, 3, 1, 1);
        frame();
        pix_check("t3_fs", t1, 2, 2, 1);
        step(1'b1, 1'b1, 4'hF, 4'h0, 1'b0, 24'h0);
        pix_check("t3_wt", t1, 3, 1, 1);
        // Pixel coincident with frame_start uses the old config
        step(1'b0, 1'b1, 4'b1101, 4'h0, 1'b0, 24'h0);
        step(1'b1, 1'b0, 4'h0, 4'h0, 1'b1, t1);
        idle();
        cmp("t3_coinc_code", int'(out_code), 3);
        pix_check("t3_after", t1, 2, 2, 1);

        // Test 4: flash half-period
        do_reset();
        step(1'b1, 1'b1, 4'hF, 4'b0001, 1'b0, 24'h0);
        pix_check("t4_f1", pk(5, 3, 0, 0), 5, 0, 1);
        repeat (14) frame();
        pix_check("t4_f15", pk(5, 3, 0, 0), 5, 0, 1);
        cmp("t4_ph15", int'(flash_phase), 0);
        frame();
        cmp("t4_ph16", int'(flash_phase), 1);
        pix_check("t4_f16", pk(5, 3, 0, 0), 3, 1, 1);
        repeat (16) frame();
        cmp("t4_ph32", int'(flash_phase), 0);
        pix_check("t4_f32", pk(5, 3, 0, 0), 5, 0, 1);

        // Test 5: valid pattern with bubbles
        begin
            logic pat[7] = '{1, 1, 0, 1, 1, 1, 0};
            for (int k = 0; k < 7; k++) begin
                step(1'b0, 1'b0, 4'h0, 4'h0, pat[k], pk(20 + k, 0, 0, 0));
            end
            idle();
            idle();
        end

        // Test 6: async reset mid-stream with flash active and enable changed
        repeat (16) frame();
        step(1'b1, 1'b1, 4'b0110, 4'b0011, 1'b1, pk(5, 3, 2, 4));
        step(1'b0, 1'b0, 4'h0, 4'h0, 1'b1, pk(7, 8, 9, 10));
        cmp("t6_pre_phase", int'(flash_phase), 1);
        pix_valid = 1'b1;
        #2 Reset_n = 1'b0;
        #1;
        cmp("t6_rst_valid", int'(out_valid), 0);
        cmp("t6_rst_code", int'(out_code), 0);
        cmp("t6_rst_layer", int'(out_layer), 0);
        cmp("t6_rst_hit", int'(out_hit), 0);
        cmp("t6_rst_phase", int'(flash_phase), 0);
        pix_valid = 1'b0;
        @(negedge Clk);
        Reset_n = 1'b1;
        m_reset();
        idle();
        cmp("t6_no_out", int'(out_valid), 0);
        pix_check("t6_t1", t1, 3, 1, 1);

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            logic [23:0] c;
            for (int i = 0; i < NL; i++) begin
                c[i*CW +: CW] = ($urandom_range(0, 2) == 0) ? 6'd0 : 6'($urandom_range(0, 63));
            end
            step($urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0, 4'($urandom),
                 4'($urandom), $urandom_range(0, 4) != 0, c);
        end
        idle();
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
